// File: rtl/alu_seq_obf.sv
// alu_seq_obf: sequential locked ALU with an iterative shift-add multiplier.
//
// On acceptance of a transaction the working key (locking_key[W+1:0]) is captured,
// the locked ALU result (out1/cout) is computed and registered, and a W-cycle
// shift-add multiplication of in3 by the key-unmasked constant is started. The
// results are presented with out_valid until the consumer asserts out_ready.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     operands/op valid
//   in_ready     block can accept a transaction (registered state only)
//   op           requested (locked) operation
//   in1, in2     ALU operands
//   in3          multiplicand
//   locking_key  key; only bits [W+1:0] are used
//   out_valid    results valid
//   out_ready    consumer accepts results
//   out1         ALU result, W bits
//   cout         carry (add) / borrow (sub); 0 for logic ops
//   out2         in3 * effective constant, modulo 2^W
module alu_seq_obf #(
  parameter int unsigned W            = 8,
  parameter int unsigned LK_W         = 255,
  parameter logic [W-1:0] LOCKED_CONST = W'(8'hD6)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [W-1:0]    in1,
  input  logic [W-1:0]    in2,
  input  logic [W-1:0]    in3,
  input  logic [LK_W-1:0] locking_key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out1,
  output logic            cout,
  output logic [W-1:0]    out2
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] CntLast = CW'(W - 1);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StMul  = 2'b01;
  localparam logic [1:0] StDone = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W+1:0]  key_q, key_d;
  logic [W-1:0]  in3_q, in3_d;
  logic [W-1:0]  out1_q, out1_d;
  logic          cout_q, cout_d;
  logic [W-1:0]  out2_q, out2_d;

  logic [W+1:0] wk;
  logic [1:0]   eop;
  logic [W:0]   sum_ext;
  logic [W:0]   diff_ext;
  logic [W-1:0] alu_res;
  logic         alu_cout;
  logic [W-1:0] c_eff;
  logic [W-1:0] addend;
  logic [W-1:0] acc_sum;

  assign wk  = locking_key[W+1:0];
  assign eop = op ^ wk[1:0];

  // Key bits above the working key are intentionally ignored.
  if (LK_W > W + 2) begin : g_unused_key
    logic unused_key_bits;
    assign unused_key_bits = ^locking_key[LK_W-1:W+2];
  end

  // ALU operates on live inputs; its result is only captured on accept.
  always_comb begin
    sum_ext  = {1'b0, in1} + {1'b0, in2};
    diff_ext = {1'b0, in1} - {1'b0, in2};
    alu_res  = '0;
    alu_cout = 1'b0;
    case (eop)
      2'b00: begin
        alu_res  = sum_ext[W-1:0];
        alu_cout = sum_ext[W];
      end
      2'b01: begin
        alu_res  = diff_ext[W-1:0];
        alu_cout = diff_ext[W];  // borrow: set when in1 < in2
      end
      2'b10:   alu_res = in1 & in2;
      default: alu_res = in1 | in2;
    endcase
  end

  // Multiplier uses the captured key so in-flight key changes have no effect.
  assign c_eff   = LOCKED_CONST ^ key_q[W+1:2];
  assign addend  = c_eff[cnt_q] ? (in3_q << cnt_q) : '0;
  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    key_d   = key_q;
    in3_d   = in3_q;
    out1_d  = out1_q;
    cout_d  = cout_q;
    out2_d  = out2_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          key_d   = wk;
          in3_d   = in3;
          out1_d  = alu_res;
          cout_d  = alu_cout;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          out2_d  = acc_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      key_q   <= '0;
      in3_q   <= '0;
      out1_q  <= '0;
      cout_q  <= 1'b0;
      out2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      key_q   <= key_d;
      in3_q   <= in3_d;
      out1_q  <= out1_d;
      cout_q  <= cout_d;
      out2_q  <= out2_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out1      = out1_q;
  assign cout      = cout_q;
  assign out2      = out2_q;

endmodule

// File: tb/tb_alu_seq_obf.sv
// Self-checking bench for alu_seq_obf (W=8). A behavioural model computes the
// expected results with plain integer arithmetic; a negedge process compares the
// DUT against it whenever out_valid is high, and directed vectors pin the model
// with hand-computed literals.
module tb_alu_seq_obf;

  localparam int unsigned W    = 8;
  localparam int unsigned LK_W = 255;
  localparam logic [W-1:0] LC  = 8'hD6;
  localparam int unsigned MOD  = 1 << W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [W-1:0]    in1, in2, in3;
  logic [LK_W-1:0] locking_key;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out1;
  logic            cout;
  logic [W-1:0]    out2;

  int n_pass  = 0;
  int n_total = 0;

  logic         exp_pending = 1'b0;
  logic [W-1:0] exp_out1;
  logic         exp_cout;
  logic [W-1:0] exp_out2;

  alu_seq_obf #(
    .W           (W),
    .LK_W        (LK_W),
    .LOCKED_CONST(LC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .locking_key(locking_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out1       (out1),
    .cout       (cout),
    .out2       (out2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference behaviour from the operation table, using integer arithmetic.
  function automatic void model(input logic [1:0] mop, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] m,
                                input logic [LK_W-1:0] key, output logic [W-1:0] o1,
                                output logic co, output logic [W-1:0] o2);
    int unsigned ia, ib, im, cval, r, eop;
    ia   = a;
    ib   = b;
    im   = m;
    eop  = int'(mop ^ key[1:0]);
    cval = int'(LC ^ key[W+1:2]);
    co   = 1'b0;
    r    = 0;
    case (eop)
      0: begin r = ia + ib; co = (r >= MOD); end
      1: begin r = (ia + MOD - ib) % MOD; co = (ia < ib); end
      2: r = ia & ib;
      default: r = ia | ib;
    endcase
    o1 = W'(r % MOD);
    o2 = W'((im * cval) % MOD);
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      check("valid_without_txn", {31'd0, exp_pending}, 32'd1);
      if (exp_pending) begin
        check("model_out1", {24'd0, out1}, {24'd0, exp_out1});
        check("model_cout", {31'd0, cout}, {31'd0, exp_cout});
        check("model_out2", {24'd0, out2}, {24'd0, exp_out2});
        check("model_ready_in_done", {31'd0, in_ready}, 32'd0);
      end
    end
  end

  // Accept on the first edge with in_ready high, wait for out_valid, optionally
  // stall, then hand-shake. Latency counts edges from the accept edge inclusive.
  task automatic run_txn(input logic [1:0] t_op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] m, input logic [LK_W-1:0] key, input int stall,
                         input bit key_flip, output logic [W-1:0] o1, output logic co,
                         output logic [W-1:0] o2);
    int lat;
    int guard;
    logic [W-1:0] h1, h2;
    logic         hc;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_ready !== 1'b1) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    op          = t_op;
    in1         = a;
    in2         = b;
    in3         = m;
    locking_key = key;
    in_valid    = 1'b1;
    @(posedge clk);
    model(t_op, a, b, m, key, exp_out1, exp_cout, exp_out2);
    exp_pending = 1'b1;
    #1;
    in_valid = 1'b0;
    in1      = ~a;
    in2      = a ^ b;
    in3      = ~m;
    op       = ~t_op;
    if (key_flip) locking_key = '1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, W + 1);
    h1 = out1;
    hc = cout;
    h2 = out2;
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out1_stable", {24'd0, out1}, {24'd0, h1});
      check("stall_out2_stable", {24'd0, out2}, {24'd0, h2});
      check("stall_cout_stable", {31'd0, cout}, {31'd0, hc});
    end
    in_valid = 1'b0;
    o1 = out1;
    co = cout;
    o2 = out2;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_pending = 1'b0;
    out_ready   = 1'b0;
    check("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] r1, r2;
    logic         rc;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    op          = 2'b00;
    in1         = '0;
    in2         = '0;
    in3         = '0;
    locking_key = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out1", {24'd0, out1}, 32'd0);
    check("rst_out2", {24'd0, out2}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Add with carry; product 3 * 0xD6 = 0x282.
    run_txn(2'b00, 8'h80, 8'h90, 8'h03, '0, 0, 1'b0, r1, rc, r2);
    check("add_out1", {24'd0, r1}, 32'h10);
    check("add_cout", {31'd0, rc}, 32'd1);
    check("add_out2", {24'd0, r2}, 32'h82);

    // Key flips add into subtract: 5 - 7 borrows.
    run_txn(2'b00, 8'h05, 8'h07, 8'h01, LK_W'(2'b01), 0, 1'b0, r1, rc, r2);
    check("sub_out1", {24'd0, r1}, 32'hFE);
    check("sub_cout", {31'd0, rc}, 32'd1);
    check("sub_out2", {24'd0, r2}, 32'hD6);

    // Key flips subtract into AND.
    run_txn(2'b01, 8'h05, 8'h07, 8'h00, LK_W'(2'b11), 0, 1'b0, r1, rc, r2);
    check("and_out1", {24'd0, r1}, 32'h05);
    check("and_cout", {31'd0, rc}, 32'd0);

    // Constant unmasked to 0x01, then to 0x00.
    run_txn(2'b00, 8'h01, 8'h02, 8'h5A, LK_W'(10'h35C), 0, 1'b0, r1, rc, r2);
    check("c1_out2", {24'd0, r2}, 32'h5A);
    check("c1_out1", {24'd0, r1}, 32'h03);
    run_txn(2'b00, 8'h01, 8'h02, 8'h5A, LK_W'(10'h358), 0, 1'b0, r1, rc, r2);
    check("c0_out2", {24'd0, r2}, 32'h00);

    // Backpressure: OR, 0xFF * 0xD6 = 0xD52A.
    run_txn(2'b11, 8'hA0, 8'h0C, 8'hFF, '0, 5, 1'b0, r1, rc, r2);
    check("bp_out1", {24'd0, r1}, 32'hAC);
    check("bp_cout", {31'd0, rc}, 32'd0);
    check("bp_out2", {24'd0, r2}, 32'h2A);

    // Reset during the fourth multiply cycle.
    op          = 2'b00;
    in1         = 8'h33;
    in2         = 8'h44;
    in3         = 8'h77;
    locking_key = '0;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_mul_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_out1", {24'd0, out1}, 32'd0);
    check("mrst_out2", {24'd0, out2}, 32'd0);
    check("mrst_cout", {31'd0, cout}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    run_txn(2'b01, 8'h10, 8'h10, 8'h02, '0, 0, 1'b0, r1, rc, r2);
    check("after_rst_out1", {24'd0, r1}, 32'h00);
    check("after_rst_cout", {31'd0, rc}, 32'd0);
    check("after_rst_out2", {24'd0, r2}, 32'hAC);

    // Key driven to all-ones while the multiply is in flight.
    run_txn(2'b00, 8'hFF, 8'h01, 8'h11, '0, 0, 1'b1, r1, rc, r2);
    check("kflip_out1", {24'd0, r1}, 32'h00);
    check("kflip_cout", {31'd0, rc}, 32'd1);
    check("kflip_out2", {24'd0, r2}, 32'h36);

    // Additional directed vectors checked against the model only.
    run_txn(2'b10, 8'h3C, 8'h0F, 8'h81, LK_W'(10'h2A6), 1, 1'b0, r1, rc, r2);
    run_txn(2'b01, 8'h00, 8'hFF, 8'hFF, LK_W'(10'h3FD), 0, 1'b0, r1, rc, r2);
    run_txn(2'b11, 8'h55, 8'hAA, 8'h7F, {LK_W{1'b1}}, 2, 1'b0, r1, rc, r2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq_obf.md
Name: alu_seq_obf

Overview:
- Parametrised, sequential successor to the single-cycle locked ALU.
- Computes a W-bit locked arithmetic/logic result (out1, cout) and a W-bit product of in3 with a locked constant (out2).
- The product uses an iterative shift-add multiplier. Transactions use valid/ready handshakes on input and output.
- Sits in the obfuscated datapath library. All opcode and constant locking comes from locking_key.

Parameters:
- W, 8, datapath width of in1/in2/in3/out1/out2 (W >= 2).
- LK_W, 255, width of locking_key; must be >= W+2.
- LOCKED_CONST, 8'hD6 (W bits), constant stored in RTL before key unmasking.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands/op valid.
- in_ready  output  1  block can accept a transaction.
- op  input  2  requested operation (locked).
- in1  input  W  ALU operand A.
- in2  input  W  ALU operand B.
- in3  input  W  multiplicand.
- locking_key  input  LK_W  key; only bits [W+1:0] are used (working key).
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.
- out1  output  W  ALU result.
- cout  output  1  carry (add) / borrow (sub); 0 for logic ops.
- out2  output  W  in3 * effective constant, modulo 2^W.

Behaviour:
- Working key: wk = locking_key[W+1:0]. It is latched into a key register on the accept cycle. Key changes after accept do not affect the in-flight transaction.
- Effective op: eop = op ^ wk[1:0].
  - 00: in1 + in2
  - 01: in1 - in2
  - 10: in1 & in2
  - 11: in1 | in2
- Effective constant: C = LOCKED_CONST ^ wk[W+1:2].
- Width rules:
  - out1 is truncated to W bits.
  - cout is bit W of the (W+1)-bit add, or the borrow of the subtract (1 when in1 < in2 unsigned).
  - out2 is truncated to W bits.
- Reset: a rising clk with rst_n=0 forces state=IDLE, out_valid=0, out1=0, out2=0, cout=0, counter=0, accumulator=0. Reset applied mid-operation aborts the transaction with no output.
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in1/in2/in3/op/wk. Compute out1/cout into the result registers. Clear the accumulator, set counter=0, go to MUL.
  - MUL: in_ready=0. Each cycle, if C[counter]=1, add (in3 << counter) mod 2^W to the accumulator; increment counter. After the cycle with counter=W-1, go to DONE and load out2 from the final accumulator.
  - DONE: out_valid=1; out1/out2/cout are held stable. On out_ready=1, go to IDLE (out_valid=0 next cycle).
- Latency: out_valid rises W+1 cycles after the accept edge (9 for W=8).
- Throughput: one transaction per W+2 cycles minimum. There is no accept in the same cycle as the DONE handshake.
- in_valid is ignored outside IDLE. Operands may change freely after accept.
- in_ready is a function of registered state only; no combinational path from in_valid.
- out_ready held low stalls indefinitely in DONE, with outputs stable.
- C=0 gives out2=0. Multiplier overflow wraps modulo 2^W.

Test Plan:
- Add with carry: W=8, key=0, op=00, in1=0x80, in2=0x90, in3=0x03 → out1=0x10, cout=1, out2=0x82 (0x282 truncated); out_valid exactly 9 cycles after accept.
- Key-flipped op: key[1:0]=01, op=00, in1=0x05, in2=0x07 → subtract: out1=0xFE, cout=1. Repeat with key[1:0]=11, op=01 → AND=0x05, cout=0.
- Constant unmask: key[9:2]=0xD7 (C=0x01), in3=0x5A → out2=0x5A. With key[9:2]=0xD6 (C=0x00) → out2=0x00.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid stays 1, outputs unchanged, in_ready=0, in_valid pulses ignored. Raise out_ready → IDLE next cycle, in_ready=1.
- Reset mid-MUL: rst_n=0 at 4th MUL cycle → next edge: out_valid=0, out1=out2=cout=0, in_ready=1. A following transaction completes correctly.
- Key change in flight: accept with key=0, then set locking_key to all-ones during MUL → results match the key=0 expectation.
